aes_iter_core: RTL
==================

Name: aes_iter_core

Overview:
- Parametrised iterative AES block core: executes one full round per clock on a single 128-bit state register.
- Supports AES-128/192/256 via NK, and both encryption and decryption (standard inverse cipher), selected per block at accept time.
- Uses a valid/ready handshake on input and output; back-to-back blocks overlap output drain with the next accept.
- Sits between the key-expansion block, which supplies the full round-key schedule, and the mode/stream wrappers (ECB/CBC/CTR).

Parameters:
- NK, 4, key length in 32-bit words. Legal values are 4, 6 and 8; any other value is an elaboration error.
- NR, NK+6, number of rounds. Derived localparam, not overridable.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- k_sch  in  128*(NR+1)  forward round-key schedule; round key r at k_sch[128*r +: 128]
- in_valid  in  1  input block offered
- in_ready  out  1  core can accept a block this cycle
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on accept
- in_data  in  128  plaintext (encrypt) or ciphertext (decrypt)
- out_valid  out  1  result held on out_data
- out_ready  in  1  downstream accepts result
- out_data  out  128  result block
- busy  out  1  high while in ROUND state

Behaviour:
- Byte order follows FIPS-197. Bits [127:120] are input byte 0 = s[0,0]. Column c occupies [127-32c -: 32]. Row 0 is the MSB byte of each column.
- FSM states: IDLE, ROUND, DONE. Reset enters IDLE with out_valid=0, busy=0, out_data=0, round counter=0, mode flag=0.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready, with no dependency on in_valid.
- Accept occurs when in_valid && in_ready at a rising edge. On that edge:
  - mode flag <= in_decrypt.
  - state_reg <= in_data ^ k_sch[0] for encrypt, or in_data ^ k_sch[NR] for decrypt.
  - round counter <= 1; FSM -> ROUND.
- ROUND, encrypt, counter r:
  - r < NR: state_reg <= MixColumns(ShiftRows(SubBytes(s))) ^ k_sch[r].
  - r == NR: same but without MixColumns.
- ROUND, decrypt, counter r:
  - r < NR: state_reg <= InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ k_sch[NR-r]).
  - r == NR: state_reg <= InvSubBytes(InvShiftRows(s)) ^ k_sch[0].
- Counter increments each ROUND cycle. After the r == NR edge, FSM -> DONE and out_valid=1.
- Latency: out_valid is first high exactly NR cycles after the accept edge (10/12/14 for NK=4/6/8).
- out_data is driven directly from state_reg. It is stable throughout DONE and is not modified until the next accept.
- DONE with out_ready=1: output handshake completes.
  - If in_valid=1 in the same cycle, the new block is accepted (-> ROUND, out_valid=0 next cycle).
  - Otherwise -> IDLE, out_valid=0.
  - Sustained throughput is one block per NR+1 cycles.
- DONE with out_ready=0: hold indefinitely. out_valid and out_data stay stable and in_ready=0.
- Signals ignored outside an accept: in_valid, in_data and in_decrypt have no effect in ROUND or in IDLE when in_valid=0.
- k_sch must be held stable from the accept edge through the last ROUND edge; the core does not latch it. Changing it mid-block is a protocol violation and the result is undefined.
- rst_n low at any edge, including mid-ROUND or in DONE: the block is discarded and all registers return to reset values the same edge. Reset dominates a simultaneous accept.
- Arithmetic: xtime = shift left 1 and XOR 8'h1b if the MSB was set. InvMixColumns coefficients are {0e,0b,0d,09}.
- S-box and inverse S-box are implemented as constant 256-entry ROM functions. No multicycle paths.

Test Plan:
- NK=4, encrypt, k_sch expanded from key 000102030405060708090a0b0c0d0e0f, in_data 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid high exactly 10 cycles after the accept edge; busy high for 10 cycles.
- NK=4, decrypt, same key, in_data 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff. Additionally, key 2b7e151628aed2a6abf7158809cf4f3c with pt 3243f6a8885a308d313198a2e0370734 -> encrypt output 3925841d02dc09fbdc118597196a0b32.
- NK=6 and NK=8 builds, keys 00..17 and 00..1f, pt 00112233445566778899aabbccddeeff -> dda97ca4864cdfe06eaf70a0ec0d7191 at latency 12, and 8ea2b7ca516745bfeafc49904b496089 at latency 14. Decrypting each result returns the pt.
- Back-pressure and streaming: hold out_ready=0 for 20 cycles after out_valid -> out_data stable and in_ready=0 throughout. Then raise out_ready with in_valid=1 and alternating in_decrypt -> 8 blocks complete at one per 11 cycles (NK=4), all outputs matching the reference model.
- Reset mid-operation: assert rst_n=0 for one cycle at round 5 -> next cycle state is IDLE, out_valid=0, out_data=0, in_ready=1. A subsequently accepted block produces the correct result with no residue from the aborted one.
- Reset in DONE with in_valid=1 and out_ready=1 on the same edge -> no accept occurs, out_valid=0, FSM in IDLE.

Source files
------------

// File: rtl/aes_iter_core.sv
// Iterative AES block core. One full round runs per clock on a single 128-bit
// state register. NK selects AES-128/192/256. Encrypt or decrypt (standard
// inverse cipher) is chosen per block when the block is accepted.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds data stable while valid is high. in_ready depends
// only on the FSM state and out_ready, never on in_valid. out_valid stays high
// with out_data stable until out_ready is seen high.
module aes_iter_core #(
    parameter int NK = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [128*(NK+7)-1:0] k_sch,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_decrypt,
    input  logic [127:0]          in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [127:0]          out_data,
    output logic                  busy
);

    localparam int NR = NK + 6;
    localparam logic [3:0] NR_W = 4'(NR);

    generate
        if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
            $error("aes_iter_core: NK must be 4, 6 or 8");
        end
    endgenerate

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Byte 0 of the ROM sits in the MSBs of the packed table.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8*int'(b) -: 8];
    endfunction

    // Bit position of the MSB of state byte s[r,c] (FIPS-197 column-major order).
    function automatic int bpos(input int r, input int c);
        return 127 - 8*(r + 4*c);
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[8*i +: 8] = inv ? inv_sbox(s[8*i +: 8]) : sbox(s[8*i +: 8]);
        return o;
    endfunction

    // Row r rotates left by r for the forward cipher, right by r for the inverse.
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[bpos(r, c) -: 8] = s[bpos(r, inv ? (c + 4 - r) % 4 : (c + r) % 4) -: 8];
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = a;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // Multiples 9, b, d, e built from the x2/x4/x8 xtime chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] b [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        {b[0], b[1], b[2], b[3]} = a;
        for (int i = 0; i < 4; i++) begin
            x2 = xt(b[i]);
            x4 = xt(x2);
            x8 = xt(x4);
            m9[i] = x8 ^ b[i];
            mb[i] = x8 ^ x2 ^ b[i];
            md[i] = x8 ^ x4 ^ b[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            o[127 - 32*c -: 32] = inv ? inv_mix_col(s[127 - 32*c -: 32])
                                      : mix_col(s[127 - 32*c -: 32]);
        return o;
    endfunction

    state_t       state;
    logic [127:0] state_reg;
    logic [3:0]   rnd;
    logic         dec;
    logic         out_valid_q;
    logic         busy_q;

    logic         accept;
    logic [127:0] load_val;
    logic [3:0]   kidx;
    logic [127:0] rk;
    logic [127:0] enc_core;
    logic [127:0] dec_core;
    logic [127:0] round_out;

    assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign load_val  = in_data ^ (in_decrypt ? k_sch[128*NR +: 128] : k_sch[127:0]);
    assign out_data  = state_reg;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    // Next state value for the current round; decrypt walks the key schedule backwards.
    always_comb begin
        kidx = dec ? (NR_W - rnd) : rnd;
        rk   = '0;
        for (int i = 0; i <= NR; i++)
            if (kidx == 4'(i)) rk = k_sch[128*i +: 128];
        enc_core = shift_rows(sub_bytes(state_reg, 1'b0), 1'b0);
        dec_core = sub_bytes(shift_rows(state_reg, 1'b1), 1'b1);
        if (!dec)
            round_out = (rnd == NR_W) ? (enc_core ^ rk) : (mix_columns(enc_core, 1'b0) ^ rk);
        else
            round_out = (rnd == NR_W) ? (dec_core ^ rk) : mix_columns(dec_core ^ rk, 1'b1);
    end

    // Control FSM with registered out_valid/busy; accept from DONE overlaps the drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            state_reg   <= '0;
            rnd         <= '0;
            dec         <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        dec         <= in_decrypt;
                        state_reg   <= load_val;
                        rnd         <= 4'd1;
                        state       <= S_ROUND;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else if (state == S_DONE && out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                S_ROUND: begin
                    state_reg <= round_out;
                    rnd       <= rnd + 4'd1;
                    if (rnd == NR_W) begin
                        state       <= S_DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
